// File: rtl/fan_speed_scheduler.sv
// Fan speed sequencer: temperature/manual target selection, kick-start from standstill,
// then a rate-limited ramp of the PWM duty word toward the registered target.
module fan_speed_scheduler #(
   parameter logic [7:0]  T_LOW       = 8'd25,
   parameter logic [7:0]  GAIN        = 8'd16,
   parameter logic [7:0]  KICK_SPEED  = 8'd200,
   parameter int unsigned KICK_CYCLES = 64,
   parameter int unsigned RAMP_DIV    = 16,
   parameter logic [7:0]  RAMP_STEP   = 8'd8
) (
   input  logic       clk,
   input  logic       arst,
   input  logic [7:0] temp,
   input  logic       temp_valid,
   input  logic       manual_en,
   input  logic [7:0] manual_speed,
   output logic [7:0] speed,
   output logic       fan_on,
   output logic       at_target,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      StOff  = 2'd0,
      StKick = 2'd1,
      StRamp = 2'd2,
      StHold = 2'd3
   } state_e;

   localparam int unsigned CntW = (KICK_CYCLES > 1) ? $clog2(KICK_CYCLES) : 1;
   localparam int unsigned DivW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam logic [CntW-1:0] KickLast = CntW'(KICK_CYCLES - 1);
   localparam logic [DivW-1:0] DivLast  = DivW'(RAMP_DIV - 1);

   state_e          state_q, state_d;
   logic [7:0]      temp_q, target_q, speed_q, speed_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [DivW-1:0] div_q, div_d;

   logic [15:0] over, prod;
   logic [7:0]  auto_target, gap, step_amt;

   // 8x8 product always fits in 16 bits, so saturation needs no wrap guard
   always_comb begin
      over = {8'd0, temp_q} - {8'd0, T_LOW};
      prod = over * {8'd0, GAIN};
      if (temp_q <= T_LOW) begin
         auto_target = 8'd0;
      end else if (prod > 16'd255) begin
         auto_target = 8'hff;
      end else begin
         auto_target = prod[7:0];
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         temp_q   <= 8'd0;
         target_q <= 8'd0;
      end else begin
         if (temp_valid) temp_q <= temp;
         target_q <= manual_en ? manual_speed : auto_target;
      end
   end

   // Step is clamped to the remaining distance so the ramp lands exactly on target
   always_comb begin
      gap      = (target_q > speed_q) ? (target_q - speed_q) : (speed_q - target_q);
      step_amt = (gap < RAMP_STEP) ? gap : RAMP_STEP;
   end

   always_comb begin
      state_d = state_q;
      speed_d = speed_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      unique case (state_q)
         StOff: begin
            speed_d = 8'd0;
            if (target_q != 8'd0) begin
               state_d = StKick;
               speed_d = KICK_SPEED;
               cnt_d   = KickLast;
            end
         end
         StKick: begin
            if (cnt_q == '0) begin
               state_d = StRamp;
               div_d   = '0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StRamp: begin
            if (speed_q == target_q) begin
               state_d = (target_q == 8'd0) ? StOff : StHold;
            end else if (div_q == DivLast) begin
               speed_d = (target_q > speed_q) ? (speed_q + step_amt) : (speed_q - step_amt);
               div_d   = '0;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         StHold: begin
            if (target_q != speed_q) begin
               state_d = StRamp;
               div_d   = '0;
            end
         end
         default: state_d = StOff;
      endcase
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q <= StOff;
         speed_q <= 8'd0;
         cnt_q   <= '0;
         div_q   <= '0;
      end else begin
         state_q <= state_d;
         speed_q <= speed_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
      end
   end

   assign speed     = speed_q;
   assign state     = state_q;
   assign fan_on    = (state_q != StOff);
   assign at_target = (state_q == StHold) || ((state_q == StOff) && (target_q == 8'd0));

endmodule

// File: tb/tb_fan_speed_scheduler.sv
// Bench for fan_speed_scheduler: directed scenarios plus randomized traffic, all checked
// against an arithmetic reference model of the speed schedule.
module tb_fan_speed_scheduler;

   logic       clk = 1'b0;
   logic       arst;
   logic [7:0] temp;
   logic       temp_valid;
   logic       manual_en;
   logic [7:0] manual_speed;
   logic [7:0] speed;
   logic       fan_on;
   logic       at_target;
   logic [1:0] state;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: phase 0 off, 1 kick, 2 ramp, 3 hold
   int m_temp, m_target, m_speed, m_phase, m_kick_elapsed, m_ramp_timer;

   fan_speed_scheduler dut (
      .clk          (clk),
      .arst         (arst),
      .temp         (temp),
      .temp_valid   (temp_valid),
      .manual_en    (manual_en),
      .manual_speed (manual_speed),
      .speed        (speed),
      .fan_on       (fan_on),
      .at_target    (at_target),
      .state        (state)
   );

   always #5 clk = ~clk;

   function automatic int auto_duty(input int t);
      int d;
      if (t <= 25) return 0;
      d = (t - 25) * 16;
      return (d > 255) ? 255 : d;
   endfunction

   function automatic bit m_fan_on();
      return m_phase != 0;
   endfunction

   function automatic bit m_at_target();
      return (m_phase == 3) || (m_phase == 0 && m_target == 0);
   endfunction

   task automatic model_reset();
      m_temp = 0; m_target = 0; m_speed = 0; m_phase = 0;
      m_kick_elapsed = 0; m_ramp_timer = 0;
   endtask

   task automatic model_step();
      int nt, ntgt, diff, mag;
      if (arst) begin
         model_reset();
         return;
      end
      nt   = temp_valid ? int'(temp) : m_temp;
      ntgt = manual_en ? int'(manual_speed) : auto_duty(m_temp);
      case (m_phase)
         0: if (m_target != 0) begin
               m_phase = 1; m_speed = 200; m_kick_elapsed = 0;
            end
         1: begin
               m_kick_elapsed++;
               if (m_kick_elapsed == 64) begin m_phase = 2; m_ramp_timer = 0; end
            end
         2: if (m_speed == m_target) begin
               m_phase = (m_target == 0) ? 0 : 3;
            end else begin
               m_ramp_timer++;
               if (m_ramp_timer == 16) begin
                  m_ramp_timer = 0;
                  diff = m_target - m_speed;
                  mag  = (diff < 0) ? -diff : diff;
                  if (mag > 8) mag = 8;
                  m_speed = (diff > 0) ? m_speed + mag : m_speed - mag;
               end
            end
         default: if (m_target != m_speed) begin m_phase = 2; m_ramp_timer = 0; end
      endcase
      m_temp = nt;
      m_target = ntgt;
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      arst = 1'b1; temp_valid = 1'b0; manual_en = 1'b0; manual_speed = 8'd0; temp = 8'd0;
      cycle();
      arst = 1'b0;
   endtask

   task automatic strobe_temp(input logic [7:0] t);
      temp = t; temp_valid = 1'b1;
      cycle();
      temp_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if (speed !== 8'd0 || state !== 2'd0) begin
         n_bad++;
         $display("FAIL reset_state speed=%0d state=%0d required 0/0", speed, state);
      end
      n_cmp++;
      if (fan_on !== 1'b0 || at_target !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_flags fan_on=%b at_target=%b required 0/1", fan_on, at_target);
      end
   endtask

   task automatic test_auto_start();
      int kicks = 0;
      do_reset();
      strobe_temp(8'd30);
      for (int i = 0; i < 600 && m_phase != 3; i++) begin
         cycle();
         if (state === 2'd1) kicks++;
         n_cmp++;
         if (speed !== 8'(m_speed) || state !== 2'(m_phase)) begin
            n_bad++;
            $display("FAIL auto_track speed=%0d state=%0d required %0d/%0d",
                     speed, state, m_speed, m_phase);
         end
      end
      n_cmp++;
      if (speed !== 8'd80 || state !== 2'd3 || at_target !== 1'b1) begin
         n_bad++;
         $display("FAIL auto_hold speed=%0d state=%0d at_target=%b required 80/3/1",
                  speed, state, at_target);
      end
      n_cmp++;
      if (kicks != 64) begin
         n_bad++;
         $display("FAIL auto_kick_len cycles=%0d required 64", kicks);
      end
   endtask

   task automatic test_saturate();
      int last = 0, prev = 0;
      do_reset();
      strobe_temp(8'd45);
      for (int i = 0; i < 600 && m_phase != 3; i++) begin
         cycle();
         if (int'(speed) != last) begin prev = last; last = int'(speed); end
         n_cmp++;
         if (speed !== 8'(m_speed) || state !== 2'(m_phase)) begin
            n_bad++;
            $display("FAIL sat_track speed=%0d state=%0d required %0d/%0d",
                     speed, state, m_speed, m_phase);
         end
      end
      n_cmp++;
      if (speed !== 8'd255 || state !== 2'd3 || prev != 248) begin
         n_bad++;
         $display("FAIL sat_hold speed=%0d state=%0d prev=%0d required 255/3/248",
                  speed, state, prev);
      end
   endtask

   task automatic test_manual_override();
      do_reset();
      strobe_temp(8'd30);
      for (int i = 0; i < 600 && m_phase != 3; i++) cycle();
      manual_en = 1'b1; manual_speed = 8'd0;
      for (int i = 0; i < 400; i++) begin
         cycle();
         n_cmp++;
         if (speed !== 8'(m_speed) || state !== 2'(m_phase)) begin
            n_bad++;
            $display("FAIL manual_track speed=%0d state=%0d required %0d/%0d",
                     speed, state, m_speed, m_phase);
         end
         if (m_phase == 0) break;
      end
      n_cmp++;
      if (speed !== 8'd0 || state !== 2'd0 || fan_on !== 1'b0) begin
         n_bad++;
         $display("FAIL manual_off speed=%0d state=%0d fan_on=%b required 0/0/0",
                  speed, state, fan_on);
      end
      manual_en = 1'b0;
      for (int i = 0; i < 10 && m_phase != 1; i++) cycle();
      n_cmp++;
      if (state !== 2'd1 || speed !== 8'd200 || fan_on !== 1'b1) begin
         n_bad++;
         $display("FAIL manual_release_kick state=%0d speed=%0d fan_on=%b required 1/200/1",
                  state, speed, fan_on);
      end
   endtask

   task automatic test_kick_ignore();
      int kicks = 0;
      do_reset();
      strobe_temp(8'd30);
      for (int i = 0; i < 1200 && !(m_phase == 0 && i > 10); i++) begin
         if (i == 12) temp_valid = 1'b1;
         else temp_valid = 1'b0;
         temp = 8'd20;
         cycle();
         if (state === 2'd1) kicks++;
         n_cmp++;
         if (speed !== 8'(m_speed) || state !== 2'(m_phase)) begin
            n_bad++;
            $display("FAIL kick_track speed=%0d state=%0d required %0d/%0d",
                     speed, state, m_speed, m_phase);
         end
      end
      temp_valid = 1'b0;
      n_cmp++;
      if (kicks != 64 || speed !== 8'd0 || state !== 2'd0) begin
         n_bad++;
         $display("FAIL kick_ignore kicks=%0d speed=%0d state=%0d required 64/0/0",
                  kicks, speed, state);
      end
   endtask

   task automatic test_below_threshold();
      do_reset();
      strobe_temp(8'd25);
      for (int i = 0; i < 20; i++) cycle();
      n_cmp++;
      if (state !== 2'd0 || speed !== 8'd0 || at_target !== 1'b1 || fan_on !== 1'b0) begin
         n_bad++;
         $display("FAIL below_thresh state=%0d speed=%0d at_target=%b required 0/0/1",
                  state, speed, at_target);
      end
   endtask

   task automatic test_async_reset_mid_ramp();
      do_reset();
      manual_en = 1'b1; manual_speed = 8'd100;
      for (int i = 0; i < 600 && !(m_phase == 2 && m_speed == 120); i++) cycle();
      n_cmp++;
      if (speed !== 8'd120 || state !== 2'd2) begin
         n_bad++;
         $display("FAIL pre_reset_ramp speed=%0d state=%0d required 120/2", speed, state);
      end
      #2;
      arst = 1'b1;
      model_reset();
      #1;
      n_cmp++;
      if (speed !== 8'd0 || state !== 2'd0 || fan_on !== 1'b0) begin
         n_bad++;
         $display("FAIL async_reset speed=%0d state=%0d fan_on=%b required 0/0/0",
                  speed, state, fan_on);
      end
      cycle();
      arst = 1'b0; manual_en = 1'b0;
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         temp_valid = ($urandom_range(0, 24) == 0);
         temp       = 8'($urandom_range(0, 60));
         if ($urandom_range(0, 299) == 0) manual_en = ~manual_en;
         if ($urandom_range(0, 199) == 0)
            manual_speed = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
         arst = ($urandom_range(0, 1499) == 0);
         cycle();
         n_cmp++;
         if (speed !== 8'(m_speed) || state !== 2'(m_phase) ||
             fan_on !== m_fan_on() || at_target !== m_at_target()) begin
            n_bad++;
            $display("FAIL rand_track cyc=%0d speed=%0d state=%0d on=%b at=%b required %0d/%0d/%b/%b",
                     i, speed, state, fan_on, at_target, m_speed, m_phase,
                     m_fan_on(), m_at_target());
         end
      end
      arst = 1'b0;
   endtask

   initial begin
      arst = 1'b1; temp = 8'd0; temp_valid = 1'b0; manual_en = 1'b0; manual_speed = 8'd0;
      model_reset();
      test_reset();
      test_auto_start();
      test_saturate();
      test_manual_override();
      test_kick_ignore();
      test_below_threshold();
      test_async_reset_mid_ramp();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
